// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver.
// A 2-flop synchroniser feeds a start/data/parity/stop FSM. The FSM samples each
// bit at its middle. A valid/ready holding register presents each completed
// word with its parity and framing flags. A word that completes while the
// holding register is still full is dropped and reported by a one-cycle
// overrun pulse.
module uart_rx_param #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int K     = DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int BIT_W = $clog2(K + 1);

    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic                 sync1_q, sync2_q;
    logic                 din_s;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic                 done;
    logic                 word_perr;
    logic                 word_ferr;
    logic                 mid_bit;

    assign din_s   = sync2_q;
    assign mid_bit = (cnt_q == FULL_M1);

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM: next state, bit timing, data shift and running parity.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_err_d = stop_err_q;
        done       = 1'b0;
        word_ferr  = 1'b0;
        // The running parity covers the data bits and the parity bit. Odd
        // parity needs an odd count of ones, so a zero XOR is an error.
        word_perr  = (PARITY == 1) ? ~par_q : ((PARITY == 2) ? par_q : 1'b0);
        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                bit_d      = '0;
                par_d      = 1'b0;
                stop_err_d = 1'b0;
                if (!din_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = din_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (mid_bit) begin
                    cnt_d = '0;
                    if (LSB_FIRST != 0) begin
                        shift_d = {din_s, shift_q[DATA_BITS-1:1]};
                    end else begin
                        shift_d = {shift_q[DATA_BITS-2:0], din_s};
                    end
                    par_d = par_q ^ din_s;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (mid_bit) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    par_d   = par_q ^ din_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (mid_bit) begin
                    cnt_d = '0;
                    if (!din_s) begin
                        stop_err_d = 1'b1;
                    end
                    if (bit_q == STOP_LAST) begin
                        // Leave at mid stop bit so that a back-to-back start
                        // edge is seen on time.
                        done      = 1'b1;
                        word_ferr = stop_err_q | ~din_s;
                        state_d   = word_ferr ? S_BREAK : S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_BREAK: begin
                // A line held low must go high again before a new start counts.
                cnt_d = '0;
                if (din_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register: load, drop-with-overrun, or clear on handshake.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        if (done) begin
            if (valid_q && !m_ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
                perr_d  = word_perr;
                ferr_d  = word_ferr;
            end
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign m_data     = data_q;
    assign m_valid    = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
